fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding select plus a per-register latency
// scoreboard for long-latency ops (loads/multicycle).
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_src_rs         packed source indices, port j at [5j+4:5j]
//   i_src_used       port j reads a register this cycle
//   i_stg_rd         destination register per producer stage (stage 0 youngest)
//   i_stg_fwd_ok     stage result is valid and forwardable
//   o_fwd_sel        per-port select: 0 = register file, k = stage k-1
//   i_issue_*        long-latency issue request (rd, cycles to writeback)
//   i_wb_*           long-latency writeback
//   i_flush          clears the scoreboard and blocks issue
//   o_stall          a used source waits on a pending register
//   o_issue_ack      issue accepted this cycle
//   o_pending        registered pending bits (bit 0 always 0)
//   o_stall_cycles   saturating stall-cycle counter
module fwd_scoreboard #(
  parameter  int NUM_SRC = 2,
  parameter  int NUM_STG = 2,
  parameter  int LAT_W   = 3,
  localparam int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_SRC*5-1:0]     i_src_rs,
  input  logic [NUM_SRC-1:0]       i_src_used,
  input  logic [NUM_STG*5-1:0]     i_stg_rd,
  input  logic [NUM_STG-1:0]       i_stg_fwd_ok,
  output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
  input  logic                     i_issue_valid,
  input  logic [4:0]               i_issue_rd,
  input  logic [LAT_W-1:0]         i_issue_lat,
  input  logic                     i_wb_valid,
  input  logic [4:0]               i_wb_rd,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic                     o_issue_ack,
  output logic [31:0]              o_pending,
  output logic [31:0]              o_stall_cycles
);

  logic [31:0]      pend_q, pend_d;
  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0] fwd_hit;
  logic             stall;
  logic             ack;

  // Forward select and stall detection. Stages are scanned oldest to
  // youngest so the youngest matching stage overwrites older matches.
  always_comb begin
    logic [4:0] rs_j;
    rs_j      = '0;
    o_fwd_sel = '0;
    fwd_hit   = '0;
    stall     = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      rs_j = i_src_rs[5*j +: 5];
      for (int unsigned k = NUM_STG; k > 0; k--) begin
        if (i_stg_fwd_ok[k-1] && (i_stg_rd[5*(k-1) +: 5] == rs_j) && (rs_j != '0)) begin
          o_fwd_sel[SEL_W*j +: SEL_W] = SEL_W'(k);
          fwd_hit[j]                  = 1'b1;
        end
      end
      if (i_src_used[j] && (rs_j != '0) && pend_q[rs_j] && !fwd_hit[j])
        stall = 1'b1;
    end
  end

  assign ack = i_issue_valid && !stall && !i_flush;

  // Per-register next state. Priority (lowest to highest): countdown/expiry,
  // writeback, new issue; flush overrides everything.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      pend_d = '0;
      for (int unsigned r = 0; r < 32; r++) cnt_d[r] = '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (pend_q[r]) begin
          if (cnt_q[r] > LAT_W'(1)) begin
            cnt_d[r] = cnt_q[r] - LAT_W'(1);
          end else begin
            pend_d[r] = 1'b0;
            cnt_d[r]  = '0;
          end
        end
        if (i_wb_valid && (i_wb_rd == 5'(r))) begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end
        if (ack && (i_issue_rd == 5'(r)) && (i_issue_lat != '0)) begin
          pend_d[r] = 1'b1;
          cnt_d[r]  = i_issue_lat;
        end
      end
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q      <= '0;
      stall_cnt_q <= '0;
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign o_stall        = stall;
  assign o_issue_ack    = ack;
  assign o_pending      = pend_q;
  assign o_stall_cycles = stall_cnt_q;

endmodule
